// File: rtl/wb_trace_fifo_if.sv
// Bus bundle between the core's write taps, the trace FIFO and its consumer.
// The slave modport is the FIFO's view; master is the driving side.
interface wb_trace_fifo_if #(
   parameter int CW = 4
);
   logic          grf_we;
   logic [31:0]   grf_pc;
   logic [4:0]    grf_addr;
   logic [31:0]   grf_wdata;
   logic          dm_we;
   logic [31:0]   dm_pc;
   logic [31:0]   dm_addr;
   logic [31:0]   dm_wdata;
   logic          out_valid;
   logic          out_ready;
   logic          out_kind;
   logic [31:0]   out_pc;
   logic [31:0]   out_addr;
   logic [31:0]   out_data;
   logic [CW-1:0] count;
   logic          overflow;

   modport master (
      output grf_we, grf_pc, grf_addr, grf_wdata,
      output dm_we, dm_pc, dm_addr, dm_wdata,
      output out_ready,
      input  out_valid, out_kind, out_pc, out_addr, out_data, count, overflow
   );

   modport slave (
      input  grf_we, grf_pc, grf_addr, grf_wdata,
      input  dm_we, dm_pc, dm_addr, dm_wdata,
      input  out_ready,
      output out_valid, out_kind, out_pc, out_addr, out_data, count, overflow
   );
endinterface

// File: rtl/wb_trace_fifo.sv
// In-order queue of architectural writes (GRF then DM) from the Mips core,
// with drop-on-full and a sticky overflow flag.
module wb_trace_fifo #(
   parameter int DEPTH = 8,
   parameter int CW    = 4
) (
   input logic            clk,
   input logic            reset,
   wb_trace_fifo_if.slave bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0] rptr;
   logic [PW-1:0] wptr;
   logic [CW-1:0] count;
   logic          overflow_q;

   logic          kind_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   addr_mem [DEPTH];
   logic [31:0]   data_mem [DEPTH];

   logic          head_valid;
   logic          grf_ev;
   logic          dm_ev;
   logic          pop;
   logic          acc_grf;
   logic          acc_dm;
   logic          drop;
   logic [CW:0]   space;
   logic [PW-1:0] dm_slot;

   assign head_valid = (count != '0);

   // A same-cycle pop frees its slot, so space counts it before pushes are admitted.
   always_comb begin
      grf_ev  = bus.grf_we && (bus.grf_addr != 5'd0);
      dm_ev   = bus.dm_we;
      pop     = head_valid && bus.out_ready;
      space   = (CW+1)'(DEPTH) - (CW+1)'(count) + (CW+1)'(pop);
      acc_grf = grf_ev && (space != '0);
      acc_dm  = dm_ev && (space > (CW+1)'(acc_grf));
      drop    = (grf_ev && !acc_grf) || (dm_ev && !acc_dm);
      dm_slot = wptr + PW'(acc_grf);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rptr       <= '0;
         wptr       <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (pop) begin
            rptr <= rptr + PW'(1);
         end
         wptr  <= wptr + PW'(acc_grf) + PW'(acc_dm);
         count <= count - CW'(pop) + CW'(acc_grf) + CW'(acc_dm);
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Payload storage needs no reset: nothing is presented until count says so.
   always_ff @(posedge clk) begin
      if (reset && acc_grf) begin
         kind_mem[wptr] <= 1'b0;
         pc_mem[wptr]   <= bus.grf_pc;
         addr_mem[wptr] <= {27'd0, bus.grf_addr};
         data_mem[wptr] <= bus.grf_wdata;
      end
      if (reset && acc_dm) begin
         kind_mem[dm_slot] <= 1'b1;
         pc_mem[dm_slot]   <= bus.dm_pc;
         addr_mem[dm_slot] <= bus.dm_addr;
         data_mem[dm_slot] <= bus.dm_wdata;
      end
   end

   assign bus.out_valid = head_valid;
   assign bus.out_kind  = head_valid ? kind_mem[rptr] : 1'b0;
   assign bus.out_pc    = head_valid ? pc_mem[rptr]   : 32'd0;
   assign bus.out_addr  = head_valid ? addr_mem[rptr] : 32'd0;
   assign bus.out_data  = head_valid ? data_mem[rptr] : 32'd0;
   assign bus.count     = count;
   assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_wb_trace_fifo.sv
// Scoreboard bench for wb_trace_fifo: directed writes queue expected entries,
// a negedge monitor compares every accepted pop against them.
module tb_wb_trace_fifo;
   typedef struct packed {
      logic        kind;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] data;
   } entry_t;

   logic   clk;
   logic   reset;
   int     checks;
   int     failures;
   entry_t expq[$];

   wb_trace_fifo_if #(.CW(4)) bus ();

   wb_trace_fifo #(.DEPTH(8), .CW(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic gwe, input logic [4:0] ga, input logic [31:0] gd,
                                input logic [31:0] gpc, input logic dwe, input logic [31:0] da,
                                input logic [31:0] dd, input logic [31:0] dpc,
                                input logic expg, input logic expd);
      bus.grf_we    = gwe;
      bus.grf_addr  = ga;
      bus.grf_wdata = gd;
      bus.grf_pc    = gpc;
      bus.dm_we     = dwe;
      bus.dm_addr   = da;
      bus.dm_wdata  = dd;
      bus.dm_pc     = dpc;
      if (expg) expq.push_back('{1'b0, gpc, {27'd0, ga}, gd});
      if (expd) expq.push_back('{1'b1, dpc, da, dd});
      @(posedge clk);
      #1;
      bus.grf_we = 1'b0;
      bus.dm_we  = 1'b0;
   endtask

   // Every handshake seen just before the popping edge must match the oldest expectation.
   always @(negedge clk) begin
      if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_pop got pc=%h addr=%h data=%h expected=none",
                     bus.out_pc, bus.out_addr, bus.out_data);
         end else begin
            entry_t e;
            e = expq.pop_front();
            checkOutput("pop_kind", 32'(bus.out_kind), 32'(e.kind));
            checkOutput("pop_pc", bus.out_pc, e.pc);
            checkOutput("pop_addr", bus.out_addr, e.addr);
            checkOutput("pop_data", bus.out_data, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks        = 0;
      failures      = 0;
      reset         = 1'b0;
      bus.out_ready = 1'b0;
      bus.grf_pc    = 32'd0;
      bus.grf_wdata = 32'd0;
      bus.dm_we     = 1'b0;
      bus.dm_pc     = 32'd0;
      bus.dm_addr   = 32'd0;
      bus.dm_wdata  = 32'd0;
      // An event held across a reset edge must never be queued.
      bus.grf_we    = 1'b1;
      bus.grf_addr  = 5'd3;
      #11;
      bus.grf_we = 1'b0;
      checkOutput("reset_count", 32'(bus.count), 32'd0);
      checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset_overflow", 32'(bus.overflow), 32'd0);
      checkOutput("reset_kind", 32'(bus.out_kind), 32'd0);
      checkOutput("reset_pc", bus.out_pc, 32'd0);
      checkOutput("reset_addr", bus.out_addr, 32'd0);
      checkOutput("reset_data", bus.out_data, 32'd0);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_reset_count", 32'(bus.count), 32'd0);

      // Single GRF write with consumer ready
      bus.out_ready = 1'b1;
      applyStimulus(1'b1, 5'd8, 32'h12345678, 32'h3000, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      checkOutput("single_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("single_kind", 32'(bus.out_kind), 32'd0);
      checkOutput("single_addr", bus.out_addr, 32'd8);
      checkOutput("single_data", bus.out_data, 32'h12345678);
      checkOutput("single_pc", bus.out_pc, 32'h3000);
      @(posedge clk);
      #1;
      checkOutput("single_drained", 32'(bus.count), 32'd0);

      // $0 writes are filtered
      applyStimulus(1'b1, 5'd0, 32'hDEAD, 32'h3004, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("zero_count", 32'(bus.count), 32'd0);
      checkOutput("zero_valid", 32'(bus.out_valid), 32'd0);

      // Dual event: GRF ahead of DM
      bus.out_ready = 1'b0;
      applyStimulus(1'b1, 5'd5, 32'hA, 32'h3008, 1'b1, 32'h10, 32'hB, 32'h3008, 1'b1, 1'b1);
      checkOutput("dual_count", 32'(bus.count), 32'd2);
      checkOutput("dual_head_kind", 32'(bus.out_kind), 32'd0);
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("dual_drained", 32'(bus.count), 32'd0);

      // Overflow: ninth write is dropped
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         applyStimulus(1'b1, 5'(i), 32'(i * 16), 32'(32'h4000 + i * 4), 1'b0, 32'd0, 32'd0, 32'd0,
                       (i <= 8), 1'b0);
      end
      checkOutput("ovf_count", 32'(bus.count), 32'd8);
      checkOutput("ovf_flag", 32'(bus.overflow), 32'd1);
      bus.out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      checkOutput("ovf_drained", 32'(bus.count), 32'd0);
      checkOutput("ovf_sticky", 32'(bus.overflow), 32'd1);

      // Full FIFO with simultaneous pop and push, then streaming across wrap
      bus.out_ready = 1'b0;
      reset = 1'b0;
      expq.delete();
      #3;
      reset = 1'b1;
      checkOutput("ovf_cleared", 32'(bus.overflow), 32'd0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 5'(10 + i), 32'(32'h100 + i), 32'(32'h5000 + i * 4), 1'b0, 32'd0,
                       32'd0, 32'd0, 1'b1, 1'b0);
      end
      checkOutput("full_count", 32'(bus.count), 32'd8);
      bus.out_ready = 1'b1;
      applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 32'h2000, 32'hD00D, 32'h6000, 1'b0, 1'b1);
      checkOutput("full_swap_count", 32'(bus.count), 32'd8);
      checkOutput("full_swap_overflow", 32'(bus.overflow), 32'd0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 32'(32'h2100 + i * 4), 32'(32'hE000 + i),
                       32'(32'h6100 + i * 4), 1'b0, 1'b1);
      end
      checkOutput("stream_count", 32'(bus.count), 32'd8);
      checkOutput("stream_overflow", 32'(bus.overflow), 32'd0);
      repeat (8) @(posedge clk);
      #1;
      checkOutput("stream_drained", 32'(bus.count), 32'd0);

      // Mid-stream asynchronous reset discards the queue
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 5'(20 + i), 32'(32'h700 + i), 32'(32'h7000 + i * 4), 1'b0, 32'd0,
                       32'd0, 32'd0, 1'b1, 1'b0);
      end
      checkOutput("mid_count", 32'(bus.count), 32'd5);
      #2;
      reset = 1'b0;
      expq.delete();
      #1;
      checkOutput("mid_reset_count", 32'(bus.count), 32'd0);
      checkOutput("mid_reset_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("mid_reset_data", bus.out_data, 32'd0);
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("mid_after_count", 32'(bus.count), 32'd0);
      bus.out_ready = 1'b1;
      applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 32'h88, 32'hCAFE, 32'h7100, 1'b0, 1'b1);
      checkOutput("mid_new_count", 32'(bus.count), 32'd1);
      checkOutput("mid_new_kind", 32'(bus.out_kind), 32'd1);
      checkOutput("mid_new_data", bus.out_data, 32'hCAFE);
      @(posedge clk);
      #1;
      checkOutput("mid_new_drained", 32'(bus.count), 32'd0);
      checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
